// File: rtl/lzw_dict_ram_if.sv
// Bus between the LZW control FSM (master) and the dictionary store (slave).
// Carries the clear pulse, the read request/response and the allocating write.
interface lzw_dict_ram_if #(
    parameter int CODE_W = 13,
    parameter int CHAR_W = 8
);
    // No back-pressure on either port: a request counts in the cycle it is high
    // while busy=0. An accepted read answers with rd_valid exactly one cycle later.
    // A write that cannot be taken (busy or full) answers with a one-cycle wr_drop,
    // unless clear is high in the same cycle, in which case the write simply vanishes.
    logic              clear;
    logic              busy;
    logic              rd_en;
    logic [CODE_W-1:0] rd_addr;
    logic              rd_valid;
    logic [CODE_W-1:0] rd_prefix;
    logic [CHAR_W-1:0] rd_append;
    logic              wr_en;
    logic [CODE_W-1:0] wr_prefix;
    logic [CHAR_W-1:0] wr_append;
    logic [CODE_W-1:0] wr_code;
    logic              wr_drop;
    logic [CODE_W-1:0] next_code;
    logic              full;

    modport master (
        output clear, rd_en, rd_addr, wr_en, wr_prefix, wr_append,
        input  busy, rd_valid, rd_prefix, rd_append, wr_code, wr_drop, next_code, full
    );

    modport slave (
        input  clear, rd_en, rd_addr, wr_en, wr_prefix, wr_append,
        output busy, rd_valid, rd_prefix, rd_append, wr_code, wr_drop, next_code, full
    );
endinterface

// File: rtl/lzw_dict_ram.sv
// LZW dictionary: {prefix, append} RAM with root self-init, next-code allocation,
// full detection, write-first read forwarding and a clear/restart sequencer.
module lzw_dict_ram #(
    parameter int                CODE_W     = 13,
    parameter int                CHAR_W     = 8,
    parameter int                ADDR_W     = 12,
    parameter int                FIRST_FREE = 256,
    parameter logic [CODE_W-1:0] NULL_CODE  = '1
) (
    input  logic           clk,
    input  logic           rst_n,
    lzw_dict_ram_if.slave  bus,
    output logic           dbg_state_o
);
    localparam int                DEPTH      = 1 << ADDR_W;
    localparam int                ENTRY_W    = CODE_W + CHAR_W;
    localparam logic [CODE_W-1:0] DEPTH_CODE = CODE_W'(DEPTH);
    localparam logic [CODE_W-1:0] FIRST_CODE = CODE_W'(FIRST_FREE);
    localparam logic [ADDR_W-1:0] LAST_ROOT  = ADDR_W'(FIRST_FREE - 1);

    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [CODE_W-1:0]   next_code_q, next_code_d;
    logic                full_q, full_d;
    logic [CODE_W-1:0]   wr_code_q, wr_code_d;
    logic                wr_drop_q, wr_drop_d;
    logic                rd_valid_q, rd_valid_d;
    logic [CODE_W-1:0]   rd_prefix_q, rd_prefix_d;
    logic [CHAR_W-1:0]   rd_append_q, rd_append_d;

    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [ENTRY_W-1:0]  mem_wdata;

    logic                busy;
    logic                rd_fire;
    logic                wr_fire;
    logic                wr_hit;
    logic [ADDR_W-1:0]   raddr;
    logic [ENTRY_W-1:0]  wr_word;
    logic [ENTRY_W-1:0]  rd_word;
    logic                unused_rd_hi;

    assign busy    = (state_q == S_INIT);
    assign raddr   = bus.rd_addr[ADDR_W-1:0];
    assign wr_word = {bus.wr_prefix, bus.wr_append};
    assign rd_fire = bus.rd_en && !busy;
    assign wr_fire = bus.wr_en && !busy && !full_q && !bus.clear;

    // Codes above the RAM size are never produced, so the high address bits are don't-care.
    assign unused_rd_hi = ^bus.rd_addr[CODE_W-1:ADDR_W];

    // Write-first: a read of the slot being allocated this cycle sees the new entry.
    assign wr_hit  = wr_fire && (next_code_q[ADDR_W-1:0] == raddr);
    assign rd_word = wr_hit ? wr_word : mem[raddr];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        next_code_d = next_code_q;
        full_d      = full_q;
        wr_code_d   = wr_code_q;
        wr_drop_d   = bus.wr_en && !bus.clear && (busy || full_q);
        rd_valid_d  = rd_fire;
        rd_prefix_d = rd_prefix_q;
        rd_append_d = rd_append_q;
        mem_we      = 1'b0;
        mem_waddr   = next_code_q[ADDR_W-1:0];
        mem_wdata   = wr_word;

        if (rd_fire) begin
            rd_prefix_d = rd_word[ENTRY_W-1:CHAR_W];
            rd_append_d = rd_word[CHAR_W-1:0];
        end

        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = {NULL_CODE, cnt_q[CHAR_W-1:0]};
                if (bus.clear) begin
                    cnt_d       = '0;
                    next_code_d = FIRST_CODE;
                    full_d      = 1'b0;
                end else if (cnt_q == LAST_ROOT) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            S_RUN: begin
                if (bus.clear) begin
                    state_d     = S_INIT;
                    cnt_d       = '0;
                    next_code_d = FIRST_CODE;
                    full_d      = 1'b0;
                end else if (wr_fire) begin
                    mem_we      = 1'b1;
                    wr_code_d   = next_code_q;
                    next_code_d = next_code_q + CODE_W'(1);
                    full_d      = ((next_code_q + CODE_W'(1)) == DEPTH_CODE);
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            next_code_q <= FIRST_CODE;
            full_q      <= 1'b0;
            wr_code_q   <= '0;
            wr_drop_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_prefix_q <= '0;
            rd_append_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            next_code_q <= next_code_d;
            full_q      <= full_d;
            wr_code_q   <= wr_code_d;
            wr_drop_q   <= wr_drop_d;
            rd_valid_q  <= rd_valid_d;
            rd_prefix_q <= rd_prefix_d;
            rd_append_q <= rd_append_d;
        end
    end

    // RAM contents deliberately survive reset; roots are rebuilt by INIT.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.busy      = busy;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_prefix = rd_prefix_q;
    assign bus.rd_append = rd_append_q;
    assign bus.wr_code   = wr_code_q;
    assign bus.wr_drop   = wr_drop_q;
    assign bus.next_code = next_code_q;
    assign bus.full      = full_q;
    assign dbg_state_o   = state_q;
endmodule
